// File: rtl/synth_pkg.sv
// Shared types and constants for the song sequencer and synth voices.
// Just-intonation ratios are Q.20 fixed point.
package synth_pkg;

    localparam int FRAC_BITS = 20;
    localparam int NUM_TONES = 13;

    localparam logic [31:0] RATIO [NUM_TONES] = '{
        32'd1048576,
        32'd1118481,
        32'd1179648,
        32'd1258291,
        32'd1310720,
        32'd1398101,
        32'd1474560,
        32'd1572864,
        32'd1677721,
        32'd1747626,
        32'd1864135,
        32'd1966080,
        32'd2097152
    };

    typedef struct packed {
        logic [3:0] tone;
        logic [3:0] len;
        logic [2:0] cutoff;
    } song_step_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        LOAD,
        HOLD
    } seq_state_t;

    // Tones above the ratio table are rests and produce silence.
    function automatic logic [31:0] note_freq(
        input logic [31:0] base,
        input logic [3:0]  tone
    );
        logic [63:0] prod;
        prod = '0;
        if (tone < 4'(NUM_TONES))
            prod = (64'(base) << FRAC_BITS) * 64'(RATIO[tone]);
        return 32'(prod >> FRAC_BITS);
    endfunction

endpackage

// File: rtl/song_ram.sv
// Song memory: one write port, registered read port.
// A same-cycle write and read of one address returns the old entry.
module song_ram
    import synth_pkg::*;
#(
    parameter int STEPS = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  song_step_t               wr_data,
    input  logic [$clog2(STEPS)-1:0] rd_addr,
    output song_step_t               rd_data
);

    song_step_t mem [STEPS];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/song_sequencer.sv
// Hardware note player driving the synth voice frequencies and cutoff.
// Define SONG_SEQUENCER_LOOP_EN to repeat the song until stop or reset.
module song_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS     = 16,
    parameter int VOICES    = 8,
    parameter int BASE_FREQ = 110,
    parameter int HALF_BEAT = 12000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     sample_tick,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [3:0]               wr_tone,
    input  logic [3:0]               wr_len,
    input  logic [2:0]               wr_cutoff,
    output logic [31:0]              frequencies [VOICES],
    output logic [2:0]               cutoff,
    output logic                     busy,
    output logic                     note_strobe,
    output logic [$clog2(STEPS)-1:0] step
);

    localparam int AW = $clog2(STEPS);
    localparam int HW = $clog2(15 * HALF_BEAT);

    seq_state_t      state, state_n;
    logic [AW-1:0]   step_n;
    logic [HW-1:0]   hold, hold_init;
    logic            load_en, clear_en, hold_dec, eos;
    logic [31:0]     note;
    song_step_t      wr_data, rd_data;

    assign wr_data = '{tone: wr_tone, len: wr_len, cutoff: wr_cutoff};

    song_ram #(.STEPS(STEPS)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (step),
        .rd_data (rd_data)
    );

    assign note      = note_freq(32'(BASE_FREQ), rd_data.tone);
    assign hold_init = HW'(32'(rd_data.len) * 32'(HALF_BEAT) - 32'd1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n  = state;
        step_n   = step;
        load_en  = 1'b0;
        clear_en = 1'b0;
        hold_dec = 1'b0;
        eos      = 1'b0;
        if (stop && state != IDLE) begin
            state_n  = IDLE;
            clear_en = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state_n = FETCH;
                        step_n  = '0;
                    end
                end
                FETCH: state_n = CALC;
                CALC: begin
                    if (rd_data.len == 4'd0) begin
                        eos = 1'b1;
                    end else begin
                        state_n = LOAD;
                        load_en = 1'b1;
                    end
                end
                LOAD: state_n = HOLD;
                HOLD: begin
                    if (sample_tick) begin
                        if (hold != '0) begin
                            hold_dec = 1'b1;
                        end else if (step == AW'(STEPS - 1)) begin
                            eos = 1'b1;
                        end else begin
                            step_n  = step + 1'b1;
                            state_n = FETCH;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
            if (eos) begin
`ifdef SONG_SEQUENCER_LOOP_EN
                // A marker at step 0 would loop with no notes at all.
                if (state == CALC && step == '0) begin
                    state_n  = IDLE;
                    clear_en = 1'b1;
                end else begin
                    step_n  = '0;
                    state_n = FETCH;
                end
`else
                state_n  = IDLE;
                clear_en = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            hold        <= '0;
            cutoff      <= '0;
            note_strobe <= 1'b0;
            for (int v = 0; v < VOICES; v++)
                frequencies[v] <= '0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            note_strobe <= load_en;
            if (load_en) begin
                hold   <= hold_init;
                cutoff <= rd_data.cutoff;
                for (int v = 0; v < VOICES; v++)
                    frequencies[v] <= note << (v % 3);
            end else if (clear_en) begin
                cutoff <= '0;
                for (int v = 0; v < VOICES; v++)
                    frequencies[v] <= '0;
            end else if (hold_dec) begin
                hold <= hold - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer against a note-list reference model.
// Built with HALF_BEAT=4 so notes are short.
module tb_song_sequencer;

    localparam int STEPS  = 16;
    localparam int VOICES = 8;
    localparam int BASE   = 110;
    localparam int HB     = 4;
    localparam int AW     = $clog2(STEPS);

    localparam longint NUM [13] = '{1, 16, 9, 6, 5, 4, 45, 3, 8, 5, 16, 15, 2};
    localparam longint DEN [13] = '{1, 15, 8, 5, 4, 3, 32, 2, 5, 3, 9, 8, 1};

    logic          clk = 1'b0;
    logic          reset, start, stop, sample_tick, wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_tone, wr_len;
    logic [2:0]    wr_cutoff;
    logic [31:0]   freq [VOICES];
    logic [2:0]    cutoff;
    logic          busy, note_strobe;
    logic [AW-1:0] step;

    int n_tests = 0;
    int n_fail  = 0;
    int m_tone [STEPS];
    int m_len  [STEPS];
    int m_cut  [STEPS];

    always #5 clk = ~clk;

    song_sequencer #(
        .STEPS     (STEPS),
        .VOICES    (VOICES),
        .BASE_FREQ (BASE),
        .HALF_BEAT (HB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .sample_tick (sample_tick),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_tone     (wr_tone),
        .wr_len      (wr_len),
        .wr_cutoff   (wr_cutoff),
        .frequencies (freq),
        .cutoff      (cutoff),
        .busy        (busy),
        .note_strobe (note_strobe),
        .step        (step)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Just-intonation note: base * num/den in Q.20, then octave shift per voice.
    function automatic longint model_freq(input int tone, input int v);
        longint r, n;
        if (tone > 12)
            return 0;
        r = (NUM[tone] << 20) / DEN[tone];
        n = ((longint'(BASE) << 20) * r) >> 20;
        n = n & 64'hFFFF_FFFF;
        return (n << (v % 3)) & 64'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] freq_or();
        logic [31:0] r;
        r = '0;
        for (int v = 0; v < VOICES; v++)
            r |= freq[v];
        return r;
    endfunction

    task automatic write_step(input int a, input int t, input int l, input int c);
        wr_en     = 1'b1;
        wr_addr   = AW'(a);
        wr_tone   = 4'(t);
        wr_len    = 4'(l);
        wr_cutoff = 3'(c);
        m_tone[a] = t;
        m_len[a]  = l;
        m_cut[a]  = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_strobe(input longint prev, output int n, output bit glitch);
        n = 0;
        glitch = 1'b0;
        do begin
            @(negedge clk);
            start = 1'b0;
            sample_tick = 1'b0;
            n++;
            if (!note_strobe && freq[0] != 32'(prev))
                glitch = 1'b1;
        end while (!note_strobe && n < 12);
    endtask

    task automatic play_song();
        int q[$];
        int s, n, got, need;
        bit glitch, early;
        longint prev;
        s = 0;
        while (1) begin
            if (m_len[s] == 0)
                break;
            q.push_back(s);
            if (s == STEPS - 1)
                break;
            s++;
        end
        prev = 0;
        start = 1'b1;
        foreach (q[j]) begin
            wait_strobe(prev, n, glitch);
            check("gap", n, 3);
            check("no_glitch", glitch, 0);
            check("step", step, q[j]);
            check("busy", busy, 1);
            check("cutoff", cutoff, m_cut[q[j]]);
            for (int v = 0; v < VOICES; v++)
                check("freq", freq[v], model_freq(m_tone[q[j]], v));
            prev = model_freq(m_tone[q[j]], 0);
            need = m_len[q[j]] * HB;
            got = 0;
            early = 1'b0;
            while (got < need) begin
                @(negedge clk);
                start = 1'b0;
                if (note_strobe || step != AW'(q[j]) || freq[0] != 32'(prev))
                    early = 1'b1;
                sample_tick = ($urandom_range(0, 2) != 0);
                if (sample_tick)
                    got++;
                if ($urandom_range(0, 9) == 0)
                    start = 1'b1;
            end
            check("hold", early, 0);
        end
`ifdef SONG_SEQUENCER_LOOP_EN
        wait_strobe(prev, n, glitch);
        check("loop_strobe", note_strobe, 1);
        check("loop_step", step, 0);
        check("loop_freq", freq[0], model_freq(m_tone[q[0]], 0));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("loop_stop", busy, 0);
`else
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            sample_tick = 1'b0;
            n++;
        end while (busy && n < 12);
        check("end_idle", busy, 0);
`endif
        check("end_freq", freq_or(), 0);
        check("end_cutoff", cutoff, 0);
    endtask

    initial begin
        int n, p;
        bit glitch;
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        sample_tick = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_tone = '0;
        wr_len = '0;
        wr_cutoff = '0;
        repeat (2) @(negedge clk);
        check("rst_freq", freq_or(), 0);
        check("rst_cutoff", cutoff, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", note_strobe, 0);
        check("rst_step", step, 0);
        reset = 1'b0;

        write_step(0, 0, 2, 1);
        write_step(1, 7, 1, 5);
        write_step(2, 12, 1, 7);
        write_step(3, 3, 0, 2);
        play_song();

        write_step(0, 15, 1, 3);
        write_step(1, 13, 1, 2);
        write_step(2, 4, 0, 0);
        play_song();

        write_step(0, 0, 2, 1);
        write_step(1, 7, 3, 5);
        write_step(2, 12, 1, 7);
        write_step(3, 0, 0, 0);
        start = 1'b1;
        wait_strobe(0, n, glitch);
        check("stop_s0", step, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample_tick = 1'b1;
        end
        wait_strobe(model_freq(0, 0), n, glitch);
        check("stop_s1", step, 1);
        repeat (2) begin
            @(negedge clk);
            sample_tick = 1'b1;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_freq", freq_or(), 0);
        play_song();

        start = 1'b1;
        wait_strobe(0, n, glitch);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mrst_freq", freq_or(), 0);
        check("mrst_cutoff", cutoff, 0);
        check("mrst_busy", busy, 0);
        check("mrst_strobe", note_strobe, 0);
        check("mrst_step", step, 0);
        reset = 1'b0;
        play_song();

        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        n = 0;
        repeat (5) begin
            if (busy || note_strobe)
                n++;
            @(negedge clk);
        end
        check("start_stop_idle", n, 0);

        for (int a = 0; a < STEPS; a++)
            write_step(a, int'($urandom_range(0, 15)), 1, int'($urandom_range(0, 7)));
        play_song();

        for (int it = 0; it < 4; it++) begin
            p = int'($urandom_range(1, STEPS));
            for (int a = 0; a < STEPS; a++)
                write_step(a, int'($urandom_range(0, 15)),
                           (a == p) ? 0 : int'($urandom_range(1, 3)),
                           int'($urandom_range(0, 7)));
            play_song();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
